// File: rtl/zpu_sd_bridge.sv
// zpu_sd_bridge: block-transfer bridge between the ZPU firmware port and the
// hps_io SD interface, serving NUM_DRIVES image slots from one sector buffer.
//
// Build option: define ZPU_SD_WRITE_EN to enable block writes. Without it,
// block_wr edges are ignored, SD_WR is tied low and ZPU_IN2[7] reads 1.
//
// Ports:
//   CLK, RESET_N            clock, asynchronous active-low reset
//   ZPU_OUT2                control: [0] lba_sel, [1] block_rd, [2] block_wr, [5:3] drive
//   ZPU_OUT3                write data byte / LBA value
//   ZPU_DATA_WR/RD          data write / read strobes from firmware
//   ZPU_IO_WR               clears the ZPU-side buffer pointer
//   ZPU_IN2                 status {readonly, filetype, fileno, mount toggle, io_done}
//   ZPU_IN3                 lba_sel ? filesize : buffer byte at the pointer
//   SD_LBA/SD_RD/SD_WR      per-drive LBA and block requests to hps_io
//   SD_ACK                  per-drive acknowledge from hps_io
//   SD_BUFF_*               hps_io side of the sector buffer
//   IMG_*/IOCTL_INDEX       image mount information from hps_io
module zpu_sd_bridge #(
    parameter int unsigned NUM_DRIVES = 4,
    parameter int unsigned BLK_AW     = 9
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [31:0]               ZPU_OUT2,
    input  logic [31:0]               ZPU_OUT3,
    input  logic                      ZPU_DATA_WR,
    input  logic                      ZPU_DATA_RD,
    input  logic                      ZPU_IO_WR,
    output logic [7:0]                ZPU_IN2,
    output logic [31:0]               ZPU_IN3,
    output logic [32*NUM_DRIVES-1:0]  SD_LBA,
    output logic [NUM_DRIVES-1:0]     SD_RD,
    output logic [NUM_DRIVES-1:0]     SD_WR,
    input  logic [NUM_DRIVES-1:0]     SD_ACK,
    input  logic [BLK_AW-1:0]         SD_BUFF_ADDR,
    input  logic [7:0]                SD_BUFF_DOUT,
    output logic [7:0]                SD_BUFF_DIN,
    input  logic                      SD_BUFF_WR,
    input  logic [NUM_DRIVES-1:0]     IMG_MOUNTED,
    input  logic                      IMG_READONLY,
    input  logic [63:0]               IMG_SIZE,
    input  logic [7:0]                IOCTL_INDEX
);

    localparam int unsigned Depth = 2 ** BLK_AW;
    localparam logic [BLK_AW-1:0] ZaddrOne = 1;

    typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

    logic [7:0]              buf_mem [Depth];
    logic [7:0]              sd_din_q, zbyte_q;
    logic [BLK_AW-1:0]       zaddr_q;
    logic                    wr_d1_q, wr_d2_q, rd_d1_q, rd_d2_q, inc_q;
    logic [32*NUM_DRIVES-1:0] sd_lba_q;
    logic                    wr_rise, rd_fall, zpu_byte_wr;

    logic [2:0]              drv_sel, drive_q;
    logic                    drv_valid, ack_sel;
    logic [NUM_DRIVES-1:0]   drv_onehot, sd_rd_q;
    logic                    blk_rd_q, blk_rd_rise, io_done_q;
    state_e                  state_q;

    logic [NUM_DRIVES-1:0]   img_mnt_q, pending_q, serve;
    logic [2:0]              serve_idx, fileno_q;
    logic                    serve_any, toggle_q, ro_q;
    logic [1:0]              filetype_q;
    logic [31:0]             filesize_q;

    assign drv_sel     = ZPU_OUT2[5:3];
    assign drv_valid   = ({29'b0, drv_sel} < NUM_DRIVES);
    assign wr_rise     = wr_d1_q & ~wr_d2_q;
    assign rd_fall     = rd_d2_q & ~rd_d1_q;
    assign zpu_byte_wr = wr_rise & ~ZPU_OUT2[0];
    assign blk_rd_rise = ZPU_OUT2[1] & ~blk_rd_q;

    // Sector buffer: port A is hps_io, port B follows the ZPU pointer.
    always_ff @(posedge CLK) begin
        if (SD_BUFF_WR) buf_mem[SD_BUFF_ADDR] <= SD_BUFF_DOUT;
        if (zpu_byte_wr) buf_mem[zaddr_q] <= ZPU_OUT3[7:0];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sd_din_q <= '0;
            zbyte_q  <= '0;
        end else begin
            sd_din_q <= buf_mem[SD_BUFF_ADDR];
            zbyte_q  <= buf_mem[zaddr_q];
        end
    end

    // Strobe edge detection, pointer and per-drive LBA capture.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_d1_q  <= 1'b0;
            wr_d2_q  <= 1'b0;
            rd_d1_q  <= 1'b0;
            rd_d2_q  <= 1'b0;
            inc_q    <= 1'b0;
            zaddr_q  <= '0;
            sd_lba_q <= '0;
        end else begin
            wr_d1_q <= ZPU_DATA_WR;
            wr_d2_q <= wr_d1_q;
            rd_d1_q <= ZPU_DATA_RD;
            rd_d2_q <= rd_d1_q;
            // Post-increment lands the cycle after the byte is written.
            inc_q   <= zpu_byte_wr;
            if (ZPU_IO_WR) begin
                zaddr_q <= '0;
            end else if (inc_q | rd_fall) begin
                zaddr_q <= zaddr_q + ZaddrOne;
            end
            // Only real drive slots are matched, so out-of-range selects drop out.
            for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
                if (wr_rise && ZPU_OUT2[0] && drv_sel == 3'(i)) begin
                    sd_lba_q[32*i +: 32] <= ZPU_OUT3;
                end
            end
        end
    end

    always_comb begin
        drv_onehot = '0;
        ack_sel    = 1'b0;
        for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
            if (drv_sel == 3'(i)) drv_onehot[i] = 1'b1;
            if (drive_q == 3'(i)) ack_sel = SD_ACK[i];
        end
    end

`ifdef ZPU_SD_WRITE_EN
    logic                  blk_wr_q, blk_wr_rise;
    logic [NUM_DRIVES-1:0] sd_wr_q;
    assign blk_wr_rise = ZPU_OUT2[2] & ~blk_wr_q;
    assign SD_WR       = sd_wr_q;
`else
    assign SD_WR = '0;
`endif

    // Transfer sequencer: request, wait for ack, wait for ack release.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= StIdle;
            sd_rd_q   <= '0;
            io_done_q <= 1'b1;
            drive_q   <= '0;
            blk_rd_q  <= 1'b0;
`ifdef ZPU_SD_WRITE_EN
            sd_wr_q   <= '0;
            blk_wr_q  <= 1'b0;
`endif
        end else begin
            blk_rd_q <= ZPU_OUT2[1];
`ifdef ZPU_SD_WRITE_EN
            blk_wr_q <= ZPU_OUT2[2];
`endif
            case (state_q)
                StIdle: begin
                    // Read wins when both edges arrive together.
                    if (drv_valid && blk_rd_rise) begin
                        sd_rd_q   <= drv_onehot;
                        io_done_q <= 1'b0;
                        drive_q   <= drv_sel;
                        state_q   <= StReq;
                    end
`ifdef ZPU_SD_WRITE_EN
                    else if (drv_valid && blk_wr_rise) begin
                        sd_wr_q   <= drv_onehot;
                        io_done_q <= 1'b0;
                        drive_q   <= drv_sel;
                        state_q   <= StReq;
                    end
`endif
                end
                StReq: begin
                    if (ack_sel) begin
                        sd_rd_q <= '0;
`ifdef ZPU_SD_WRITE_EN
                        sd_wr_q <= '0;
`endif
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (!ack_sel) begin
                        io_done_q <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Mount reporting: lowest pending drive is served each cycle.
    always_comb begin
        serve     = '0;
        serve_idx = '0;
        serve_any = 1'b0;
        for (int unsigned i = 0; i < NUM_DRIVES; i++) begin
            if (!serve_any && pending_q[i]) begin
                serve_any = 1'b1;
                serve[i]  = 1'b1;
                serve_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            img_mnt_q  <= '0;
            pending_q  <= '0;
            fileno_q   <= '0;
            filetype_q <= '0;
            ro_q       <= 1'b0;
            filesize_q <= '0;
            toggle_q   <= 1'b0;
        end else begin
            img_mnt_q <= IMG_MOUNTED;
            pending_q <= (pending_q & ~serve) | (IMG_MOUNTED & ~img_mnt_q);
            if (serve_any) begin
                fileno_q   <= serve_idx;
                filetype_q <= IOCTL_INDEX[7:6];
                ro_q       <= IMG_READONLY;
                filesize_q <= IMG_SIZE[31:0];
                toggle_q   <= ~toggle_q;
            end
        end
    end

    logic ro_bit;
`ifdef ZPU_SD_WRITE_EN
    assign ro_bit = ro_q;
    logic unused_ok;
    assign unused_ok = ^{ZPU_OUT2[31:6], IMG_SIZE[63:32], IOCTL_INDEX[5:0]};
`else
    assign ro_bit = 1'b1;
    logic unused_ok;
    assign unused_ok = ^{ZPU_OUT2[31:6], ZPU_OUT2[2], IMG_SIZE[63:32], IOCTL_INDEX[5:0], ro_q};
`endif

    assign ZPU_IN2     = {ro_bit, filetype_q, fileno_q, toggle_q, io_done_q};
    assign ZPU_IN3     = ZPU_OUT2[0] ? filesize_q : {24'b0, zbyte_q};
    assign SD_LBA      = sd_lba_q;
    assign SD_RD       = sd_rd_q;
    assign SD_BUFF_DIN = sd_din_q;

endmodule

// File: tb/tb_zpu_sd_bridge.sv
// Directed bench for zpu_sd_bridge (NUM_DRIVES=4, BLK_AW=9).
module tb_zpu_sd_bridge;

    logic         clk;
    logic         rst_n;
    logic [31:0]  zpu_out2, zpu_out3;
    logic         zpu_data_wr, zpu_data_rd, zpu_io_wr;
    logic [7:0]   zpu_in2;
    logic [31:0]  zpu_in3;
    logic [127:0] sd_lba;
    logic [3:0]   sd_rd, sd_wr, sd_ack;
    logic [8:0]   sd_buff_addr;
    logic [7:0]   sd_buff_dout, sd_buff_din;
    logic         sd_buff_wr;
    logic [3:0]   img_mounted;
    logic         img_readonly;
    logic [63:0]  img_size;
    logic [7:0]   ioctl_index;

    int total = 0;
    int bad   = 0;

`ifdef ZPU_SD_WRITE_EN
    localparam logic [7:0] RoBit = 8'h00;
`else
    localparam logic [7:0] RoBit = 8'h80;
`endif

    zpu_sd_bridge #(.NUM_DRIVES(4), .BLK_AW(9)) dut (
        .CLK          (clk),
        .RESET_N      (rst_n),
        .ZPU_OUT2     (zpu_out2),
        .ZPU_OUT3     (zpu_out3),
        .ZPU_DATA_WR  (zpu_data_wr),
        .ZPU_DATA_RD  (zpu_data_rd),
        .ZPU_IO_WR    (zpu_io_wr),
        .ZPU_IN2      (zpu_in2),
        .ZPU_IN3      (zpu_in3),
        .SD_LBA       (sd_lba),
        .SD_RD        (sd_rd),
        .SD_WR        (sd_wr),
        .SD_ACK       (sd_ack),
        .SD_BUFF_ADDR (sd_buff_addr),
        .SD_BUFF_DOUT (sd_buff_dout),
        .SD_BUFF_DIN  (sd_buff_din),
        .SD_BUFF_WR   (sd_buff_wr),
        .IMG_MOUNTED  (img_mounted),
        .IMG_READONLY (img_readonly),
        .IMG_SIZE     (img_size),
        .IOCTL_INDEX  (ioctl_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   drv;
        logic [31:0]  val;
        logic [127:0] exp_lba;
    } lba_vec_t;

    lba_vec_t vecs [5];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr_pulse(input logic [31:0] v);
        zpu_out3    = v;
        zpu_data_wr = 1'b1;
        tick(1);
        zpu_data_wr = 1'b0;
        tick(4);
    endtask

    task automatic rd_pulse();
        zpu_data_rd = 1'b1;
        tick(1);
        zpu_data_rd = 1'b0;
        tick(4);
    endtask

    task automatic io_clr();
        zpu_io_wr = 1'b1;
        tick(1);
        zpu_io_wr = 1'b0;
        tick(2);
    endtask

    task automatic porta_check(input string name, input logic [8:0] a, input logic [7:0] exp);
        sd_buff_addr = a;
        tick(1);
        check(name, {120'b0, sd_buff_din}, {120'b0, exp});
    endtask

    // Drives ack high then low for the active request and checks completion.
    task automatic ack_cycle(input string name, input logic [3:0] mask);
        sd_ack = mask;
        tick(1);
        check({name, " req drop"}, {120'b0, sd_rd, sd_wr}, 128'h0);
        check({name, " busy"}, {127'b0, zpu_in2[0]}, 128'h0);
        sd_ack = 4'b0;
        tick(1);
        check({name, " io_done"}, {127'b0, zpu_in2[0]}, 128'h1);
    endtask

    function automatic logic [7:0] fill_val(input int unsigned i);
        logic [8:0] a;
        a = i[8:0];
        return (a[8] ? ~a[7:0] : a[7:0]) ^ 8'h3C;
    endfunction

    initial begin
        vecs[0] = '{3'd0, 32'h1111_1111, 128'h0000_0000_0000_0000_0000_0000_1111_1111};
        vecs[1] = '{3'd3, 32'hDEAD_BEEF, 128'hDEAD_BEEF_0000_0000_0000_0000_1111_1111};
        vecs[2] = '{3'd5, 32'h5555_5555, 128'hDEAD_BEEF_0000_0000_0000_0000_1111_1111};
        vecs[3] = '{3'd1, 32'hCAFE_F00D, 128'hDEAD_BEEF_0000_0000_CAFE_F00D_1111_1111};
        vecs[4] = '{3'd7, 32'h7777_7777, 128'hDEAD_BEEF_0000_0000_CAFE_F00D_1111_1111};

        rst_n = 1'b1;
        zpu_out2 = '0; zpu_out3 = '0;
        zpu_data_wr = 1'b0; zpu_data_rd = 1'b0; zpu_io_wr = 1'b0;
        sd_ack = '0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
        img_mounted = '0; img_readonly = 1'b0; img_size = '0; ioctl_index = '0;
        #2 rst_n = 1'b0;
        tick(3);

        check("reset in2", {120'b0, zpu_in2}, {120'b0, RoBit | 8'h01});
        check("reset in3", {96'b0, zpu_in3}, 128'h0);
        check("reset lba", sd_lba, 128'h0);
        check("reset rd/wr", {120'b0, sd_rd, sd_wr}, 128'h0);
        rst_n = 1'b1;
        tick(2);

        // LBA capture table, including out-of-range drives.
        for (int v = 0; v < 5; v++) begin
            zpu_out2 = {26'b0, vecs[v].drv, 3'b001};
            wr_pulse(vecs[v].val);
            check($sformatf("lba vec%0d", v), sd_lba, vecs[v].exp_lba);
        end

        // Drive 2: LBA then block read.
        zpu_out2 = 32'h11;
        wr_pulse(32'h1234);
        check("lba drv2", {96'b0, sd_lba[95:64]}, 128'h1234);
        zpu_out2 = 32'h12;
        tick(1);
        check("rd drv2 req", {124'b0, sd_rd}, 128'h4);
        check("rd drv2 io_done low", {127'b0, zpu_in2[0]}, 128'h0);
        ack_cycle("drv2", 4'b0100);
        zpu_out2 = 32'h0;
        tick(1);

        // Invalid drive select is ignored.
        zpu_out2 = 32'h32;
        tick(2);
        check("bad drive rd", {124'b0, sd_rd}, 128'h0);
        check("bad drive io_done", {127'b0, zpu_in2[0]}, 128'h1);
        zpu_out2 = 32'h0;
        tick(1);

        // Edges while busy are ignored.
        zpu_out2 = 32'h02;
        tick(1);
        check("drv0 req", {124'b0, sd_rd}, 128'h1);
        zpu_out2 = 32'h0;
        tick(1);
        zpu_out2 = 32'h0A;
        tick(1);
        check("busy edge ignored", {124'b0, sd_rd}, 128'h1);
        ack_cycle("drv0", 4'b0001);
        zpu_out2 = 32'h0;
        tick(1);

        // Buffer fill and read back from both ports.
        io_clr();
        wr_pulse(32'hA1);
        wr_pulse(32'hA2);
        wr_pulse(32'hA3);
        io_clr();
        check("fill b0", {96'b0, zpu_in3}, 128'hA1);
        rd_pulse();
        check("fill b1", {96'b0, zpu_in3}, 128'hA2);
        rd_pulse();
        check("fill b2", {96'b0, zpu_in3}, 128'hA3);
        porta_check("porta 0", 9'd0, 8'hA1);
        porta_check("porta 1", 9'd1, 8'hA2);
        porta_check("porta 2", 9'd2, 8'hA3);
        sd_buff_addr = 9'd3;
        sd_buff_dout = 8'h77;
        sd_buff_wr   = 1'b1;
        tick(1);
        sd_buff_wr   = 1'b0;
        rd_pulse();
        check("porta wr seen on b", {96'b0, zpu_in3}, 128'h77);

        // Full wrap of the pointer.
        io_clr();
        for (int unsigned i = 0; i < 512; i++) wr_pulse({24'b0, fill_val(i)});
        check("wrap to 0", {96'b0, zpu_in3}, {120'b0, fill_val(0)});
        rd_pulse();
        check("wrap rd 1", {96'b0, zpu_in3}, {120'b0, fill_val(1)});
        porta_check("wrap porta 256", 9'd256, fill_val(256));
        porta_check("wrap porta 300", 9'd300, fill_val(300));

        // IO_WR coincident with the post-write increment wins.
        zpu_out3    = 32'h99;
        zpu_data_wr = 1'b1;
        tick(1);
        zpu_data_wr = 1'b0;
        tick(1);
        zpu_io_wr   = 1'b1;
        tick(1);
        zpu_io_wr   = 1'b0;
        tick(2);
        check("io_wr priority", {96'b0, zpu_in3}, {120'b0, fill_val(0)});
        porta_check("priority byte at 1", 9'd1, 8'h99);

        // Simultaneous mounts.
        img_size    = 64'h8000;
        ioctl_index = 8'h80;
        img_mounted = 4'b0101;
        tick(1);
        check("mount latency", {120'b0, zpu_in2}, {120'b0, RoBit | 8'h01});
        tick(1);
        check("mount drv0", {120'b0, zpu_in2}, {120'b0, RoBit | 8'h43});
        tick(1);
        check("mount drv2", {120'b0, zpu_in2}, {120'b0, RoBit | 8'h49});
        img_mounted = 4'b0;
        zpu_out2    = 32'h01;
        tick(1);
        check("filesize", {96'b0, zpu_in3}, 128'h8000);
        img_readonly = 1'b1;
        ioctl_index  = 8'h40;
        img_size     = 64'hFFFF_FFFF_1234_5678;
        img_mounted  = 4'b1000;
        tick(2);
        check("mount drv3 ro", {120'b0, zpu_in2}, 128'hAF);
        check("filesize drv3", {96'b0, zpu_in3}, 128'h1234_5678);
        img_mounted  = 4'b0;
        img_readonly = 1'b0;
        zpu_out2     = 32'h0;
        tick(1);

        // Reset while a request is outstanding.
        zpu_out2 = 32'h02;
        tick(1);
        check("abort pre req", {124'b0, sd_rd}, 128'h1);
        rst_n    = 1'b0;
        zpu_out2 = 32'h0;
        #1;
        check("abort rd", {124'b0, sd_rd}, 128'h0);
        check("abort in2", {120'b0, zpu_in2}, {120'b0, RoBit | 8'h01});
        tick(1);
        rst_n = 1'b1;
        tick(2);
        zpu_out2 = 32'h02;
        tick(1);
        check("post abort req", {124'b0, sd_rd}, 128'h1);
        ack_cycle("post abort", 4'b0001);
        zpu_out2 = 32'h0;
        tick(1);

        // Block write, then both edges together.
        zpu_out2 = 32'h04;
        tick(1);
`ifdef ZPU_SD_WRITE_EN
        check("wr req", {124'b0, sd_wr}, 128'h1);
        ack_cycle("wr", 4'b0001);
`else
        check("wr disabled", {124'b0, sd_wr}, 128'h0);
        check("wr disabled idle", {127'b0, zpu_in2[0]}, 128'h1);
        check("wr disabled ro", {127'b0, zpu_in2[7]}, 128'h1);
`endif
        zpu_out2 = 32'h0;
        tick(1);
        zpu_out2 = 32'h06;
        tick(1);
        check("both edges rd wins", {120'b0, sd_rd, sd_wr}, 128'h10);
        ack_cycle("both", 4'b0001);
        zpu_out2 = 32'h0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
